// File: rtl/threshold_pkg.sv
// Shared pixel-pair types, BMP byte-order offsets and the frame-sink FSM states.
// Also used by the image source so both ends agree on word layout.
package threshold_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LINE,
    ACTIVE_LINE,
    DONE
  } state_t;

  localparam int PIXEL_WIDTH     = 8;
  localparam int PAIR_WORD_WIDTH = 48;

  localparam int B_EVEN_LSB = 0;
  localparam int G_EVEN_LSB = 8;
  localparam int R_EVEN_LSB = 16;
  localparam int B_ODD_LSB  = 24;
  localparam int G_ODD_LSB  = 32;
  localparam int R_ODD_LSB  = 40;

  typedef struct packed {
    logic [PIXEL_WIDTH-1:0] r;
    logic [PIXEL_WIDTH-1:0] g;
    logic [PIXEL_WIDTH-1:0] b;
  } rgb_t;

  function automatic logic [PAIR_WORD_WIDTH-1:0] pack_pair(
    input rgb_t ev,
    input rgb_t od
  );
    logic [PAIR_WORD_WIDTH-1:0] w;
    w = '0;
    w[B_EVEN_LSB +: PIXEL_WIDTH] = ev.b;
    w[G_EVEN_LSB +: PIXEL_WIDTH] = ev.g;
    w[R_EVEN_LSB +: PIXEL_WIDTH] = ev.r;
    w[B_ODD_LSB  +: PIXEL_WIDTH] = od.b;
    w[G_ODD_LSB  +: PIXEL_WIDTH] = od.g;
    w[R_ODD_LSB  +: PIXEL_WIDTH] = od.r;
    return w;
  endfunction

endpackage

// File: rtl/write_data_geometry.sv
// Row/column tracking, bottom-up row base address and sticky geometry errors.
// Rows arrive top first but are stored last-row-first, hence the decrementing base.
module write_data_geometry
  import threshold_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int ADDR_WIDTH   = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  mid_frame,
  input  logic                  beat,
  input  logic                  line_end,
  output logic                  col_ok,
  output logic                  last_row,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  line_error,
  output logic                  frame_error
);

  localparam int HALF = IMAGE_WIDTH / 2;
  localparam int CW   = $clog2(HALF + 1);
  localparam int RW   = $clog2(IMAGE_HEIGHT + 1);

  localparam logic [CW-1:0] HALF_C = CW'(HALF);
  localparam logic [RW-1:0] LAST_C = RW'(IMAGE_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP =
    ADDR_WIDTH'(HALF);
  localparam logic [ADDR_WIDTH-1:0] BASE0 =
    ADDR_WIDTH'((IMAGE_HEIGHT - 1) * HALF);

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [ADDR_WIDTH-1:0] row_base;

  assign col_ok   = (col < HALF_C);
  assign last_row = (row == LAST_C);
  assign wr_addr  = row_base + ADDR_WIDTH'(col);

  // col saturates at HALF so an over-long line cannot wrap into range
  always_ff @(posedge clk) begin
    if (reset) begin
      col         <= '0;
      row         <= '0;
      row_base    <= BASE0;
      line_error  <= 1'b0;
      frame_error <= 1'b0;
    end else if (frame_start) begin
      col         <= '0;
      row         <= '0;
      row_base    <= BASE0;
      line_error  <= 1'b0;
      frame_error <= mid_frame;
    end else if (beat) begin
      if (col_ok) begin
        col <= col + CW'(1);
      end else begin
        line_error <= 1'b1;
      end
    end else if (line_end) begin
      if (col != HALF_C) begin
        line_error <= 1'b1;
      end
      row      <= row + RW'(1);
      col      <= '0;
      row_base <= row_base - STEP;
    end
  end

endmodule

// File: rtl/write_data.sv
// Frame sink: packs pixel pairs into BMP-ordered words and stores them bottom-up.
// FSM, packing and registered memory-port outputs live here.
module write_data
  import threshold_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int ADDR_WIDTH   = 18
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       vertical_Pulse,
  input  logic                       horizontal_Pulse,
  input  logic [PIXEL_WIDTH-1:0]     data_R_Even,
  input  logic [PIXEL_WIDTH-1:0]     data_G_Even,
  input  logic [PIXEL_WIDTH-1:0]     data_B_Even,
  input  logic [PIXEL_WIDTH-1:0]     data_R_Odd,
  input  logic [PIXEL_WIDTH-1:0]     data_G_Odd,
  input  logic [PIXEL_WIDTH-1:0]     data_B_Odd,
  output logic                       mem_Write_Enable,
  output logic [ADDR_WIDTH-1:0]      mem_Address,
  output logic [PAIR_WORD_WIDTH-1:0] mem_Write_Data,
  output logic                       line_Error,
  output logic                       frame_Error,
  output logic                       done_Flag
);

  state_t state_q;
  state_t state_d;

  logic vs_q;
  logic vs_rise;
  logic frame_start;
  logic mid_frame;
  logic beat;
  logic line_end;
  logic col_ok;
  logic last_row;
  logic wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  rgb_t px_even;
  rgb_t px_odd;

  assign vs_rise = vertical_Pulse & ~vs_q;
  assign wr_en   = beat & col_ok;
  assign px_even = '{r: data_R_Even, g: data_G_Even, b: data_B_Even};
  assign px_odd  = '{r: data_R_Odd, g: data_G_Odd, b: data_B_Odd};

  // A frame restart takes priority over any beat in the same cycle
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    mid_frame   = 1'b0;
    beat        = 1'b0;
    line_end    = 1'b0;
    if (vs_rise) begin
      frame_start = 1'b1;
      mid_frame   = (state_q == WAIT_LINE) ||
                    (state_q == ACTIVE_LINE);
      state_d     = WAIT_LINE;
    end else begin
      unique case (state_q)
        WAIT_LINE: begin
          if (horizontal_Pulse) begin
            beat    = 1'b1;
            state_d = ACTIVE_LINE;
          end
        end
        ACTIVE_LINE: begin
          if (horizontal_Pulse) begin
            beat = 1'b1;
          end else begin
            line_end = 1'b1;
            state_d  = last_row ? DONE : WAIT_LINE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      vs_q             <= 1'b0;
      mem_Write_Enable <= 1'b0;
      mem_Address      <= '0;
      mem_Write_Data   <= '0;
      done_Flag        <= 1'b0;
    end else begin
      state_q          <= state_d;
      vs_q             <= vertical_Pulse;
      mem_Write_Enable <= wr_en;
      if (wr_en) begin
        mem_Address    <= wr_addr;
        mem_Write_Data <= pack_pair(px_even, px_odd);
      end
      if (frame_start) begin
        done_Flag <= 1'b0;
      end else if (line_end && last_row) begin
        done_Flag <= 1'b1;
      end
    end
  end

  write_data_geometry #(
    .IMAGE_WIDTH (IMAGE_WIDTH),
    .IMAGE_HEIGHT(IMAGE_HEIGHT),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_geometry (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .mid_frame  (mid_frame),
    .beat       (beat),
    .line_end   (line_end),
    .col_ok     (col_ok),
    .last_row   (last_row),
    .wr_addr    (wr_addr),
    .line_error (line_Error),
    .frame_error(frame_Error)
  );

endmodule
